fc_layer: RTL and testbench
===========================

# fc_layer

Fully-connected (dense) layer stage consuming the flattened pooled feature map from the 2×2 max-pool stage and producing one signed 32-bit score per output neuron. On a start pulse it latches the whole input vector, streams signed 32-bit weights from an external synchronous weight memory, and accumulates one multiply per cycle. It emits results serially on a valid/ready stream toward the classifier/argmax stage.

## Interface

- `IN_LEN`, 196: input elements per vector (14×14 pooled map).
- `OUT_LEN`, 10: output neurons.
- `FRAC`, 16: fractional bits of the Q-format; product sum is arithmetically shifted right by `FRAC`.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a pass; sampled only in IDLE.
- `in_map`  in  IN_LEN*32  signed elements, element i at bits [i*32 +: 32]; sampled on the accepted `start` cycle only.
- `w_en`  out  1  weight read strobe.
- `w_addr`  out  $clog2(IN_LEN*OUT_LEN)  weight index = o*IN_LEN + i.
- `w_data`  in  32  signed weight; valid exactly one cycle after `w_en`.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  32  signed result.
- `out_idx`  out  $clog2(OUT_LEN)  neuron index of `out_data`.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse after the last result handshake.

## Operation

- States: IDLE, MAC, DRAIN, OUT.
- IDLE: `start`=1 latches `in_map`, sets o=0, i=0, clears accumulator, goes to MAC.
- MAC: each cycle `w_en`=1, `w_addr`=o*IN_LEN+i, i increments. After issuing i=IN_LEN-1, goes to DRAIN.
- Accumulate: in the cycle after each `w_en`, acc += sext64(in_elem[i_prev]) * sext64(w_data). Products are 64-bit signed; the accumulator is 64-bit and wraps on overflow.
- DRAIN: folds in the final product. `w_en`=0. Goes to OUT.
- OUT: `out_valid`=1 and `out_idx`=o. `out_data` = (acc >>> FRAC) reduced to 32 bits according to Configuration.
  - The outputs are held stable until `out_valid && out_ready`.
  - On handshake with o<OUT_LEN-1: o++, i=0, acc cleared, goes to MAC.
  - On handshake with o=OUT_LEN-1: `done` pulses next cycle, goes to IDLE.
- `start` outside IDLE is ignored. The latched vector is unaffected.
- `w_data` is ignored in any cycle not following `w_en`=1.
- `rst` in any state: state IDLE, o=i=0, acc=0. No `done` pulse and no partial result is emitted.

## Timing

- Reset values: `w_en`=0, `w_addr`=0, `out_valid`=0, `out_data`=0, `out_idx`=0, `busy`=0, `done`=0.
- `start` accepted at cycle T: first `w_en` at T+1; last `w_en` at T+IN_LEN; DRAIN at T+IN_LEN+1; `out_valid` at T+IN_LEN+2.
- Per neuron: IN_LEN+2 cycles plus backpressure stall.
- Full pass with `out_ready` tied high: OUT_LEN*(IN_LEN+2) cycles from `start` to last handshake; `done` one cycle after it.
- Back-to-back: `start` may be accepted in the cycle `done` is high (state is IDLE).
- `busy` rises the cycle after `start` is accepted and falls with the entry to IDLE.

## Configuration

- `FC_SAT_EN` defined: the shifted 64-bit value saturates to [-2^31, 2^31-1] before output.
- `FC_SAT_EN` undefined: `out_data` is the low 32 bits of the shifted value, which wraps.
- Accumulator wrap behaviour is identical in both builds.

## Test plan

- Basic run, IN_LEN=4, OUT_LEN=2, FRAC=0, `out_ready`=1:
  - Stimulus: in=[1,2,3,4]; weights row0=[1,1,1,1], row1=[-1,0,2,1].
  - Required: (idx0, 10) at T+6, (idx1, 9) at T+12, `done` at T+13.
- Backpressure: `out_ready`=0 for 5 cycles on idx0.
  - Required: `out_data`/`out_idx` held; no `w_en` during the stall; idx1 result unchanged.
- Fixed point, FRAC=16:
  - Stimulus: in=0x00018000 (1.5), weight 0x00020000 (2.0), IN_LEN=1.
  - Required: out=0x00030000.
- Saturation:
  - Stimulus: in=0x7FFFFFFF, weight 0x7FFFFFFF, FRAC=0, IN_LEN=1.
  - Required: with `FC_SAT_EN`, out=0x7FFFFFFF; without it, out=0x00000001.
- Reset mid-MAC:
  - Stimulus: assert `rst` at T+2.
  - Required: next cycle `busy`=0 and `w_en`=0; no `out_valid` and no `done`. A fresh `start` gives correct results.
- `start` while busy:
  - Stimulus: pulse `start` with a different `in_map` during MAC.
  - Required: results match the originally latched vector; exactly OUT_LEN handshakes and one `done`.

Source files
------------

// File: rtl/fc_layer.sv
// Dense layer: latches an input vector on start, streams weights one per cycle from a
// synchronous memory and emits one Q-format score per neuron. Define FC_SAT_EN to saturate outputs.
module fc_layer #(
  parameter int IN_LEN  = 196,
  parameter int OUT_LEN = 10,
  parameter int FRAC    = 16,
  localparam int AW = (IN_LEN * OUT_LEN > 1) ? $clog2(IN_LEN * OUT_LEN) : 1,
  localparam int OW = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [IN_LEN*32-1:0] in_map,
  output logic                 w_en,
  output logic [AW-1:0]        w_addr,
  input  logic [31:0]          w_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_data,
  output logic [OW-1:0]        out_idx,
  output logic                 busy,
  output logic                 done
);

  localparam int IW = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;

  typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_t;

  state_t               state, state_nxt;
  logic [IN_LEN*32-1:0] in_vec;
  logic [OW-1:0]        o;
  logic [IW-1:0]        i, i_prev;
  logic                 pend;
  logic signed [63:0]   acc, prod, shifted;
  logic [31:0]          elem, res;
  logic                 last_i, last_o, hs;

  assign last_i = (i == IW'(IN_LEN - 1));
  assign last_o = (o == OW'(OUT_LEN - 1));
  assign hs     = (state == OUT) && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: the default assignment up front keeps this combinational block latch-free.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = MAC;
      MAC:     if (last_i) state_nxt = DRAIN;
      DRAIN:   state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = last_o ? IDLE : MAC;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the latched vector is not reset; it is always reloaded by start before it is read.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) in_vec <= in_map;
  end

  // The product pairs the weight arriving now with the element index issued last cycle.
  assign elem    = in_vec[i_prev*32 +: 32];
  assign prod    = $signed({{32{elem[31]}}, elem}) * $signed({{32{w_data[31]}}, w_data});
  assign shifted = acc >>> FRAC;

`ifdef FC_SAT_EN
  always_comb begin
    if (shifted > 64'sh0000_0000_7FFF_FFFF)      res = 32'h7FFF_FFFF;
    else if (shifted < 64'shFFFF_FFFF_8000_0000) res = 32'h8000_0000;
    else                                         res = shifted[31:0];
  end
`else
  assign res = shifted[31:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      o      <= '0;
      i      <= '0;
      i_prev <= '0;
      pend   <= 1'b0;
      acc    <= '0;
      done   <= 1'b0;
    end else begin
      pend   <= (state == MAC);
      i_prev <= i;
      done   <= hs && last_o;
      case (state)
        IDLE: if (start) begin
          o   <= '0;
          i   <= '0;
          acc <= '0;
        end
        MAC:  i <= last_i ? '0 : i + 1'b1;
        OUT:  if (out_ready) begin
          o   <= last_o ? '0 : o + 1'b1;
          i   <= '0;
          acc <= '0;
        end
        default: ;
      endcase
      if (pend) acc <= acc + prod;
    end
  end

  always_comb begin
    w_en      = 1'b0;
    w_addr    = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_idx   = '0;
    busy      = (state != IDLE);
    if (state == MAC) begin
      w_en   = 1'b1;
      w_addr = AW'(o) * AW'(IN_LEN) + AW'(i);
    end
    if (state == OUT) begin
      out_valid = 1'b1;
      out_data  = res;
      out_idx   = o;
    end
  end

endmodule

// File: tb/tb_fc_layer.sv
// Scoreboard bench for fc_layer: small directed instances plus a full-size random instance.
module tb_fc_layer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;

  function automatic logic [31:0] reduce(input logic signed [63:0] acc, input int frac);
    logic signed [63:0] s;
    s = acc >>> frac;
`ifdef FC_SAT_EN
    if (s > 64'sh0000_0000_7FFF_FFFF) return 32'h7FFF_FFFF;
    if (s < 64'shFFFF_FFFF_8000_0000) return 32'h8000_0000;
`endif
    return s[31:0];
  endfunction

  logic rst, a_rst;

  // ---------------- instance A: IN_LEN=4, OUT_LEN=2, FRAC=0 ----------------
  logic         a_start, a_ready, a_w_en, a_valid, a_busy, a_done;
  logic [127:0] a_in;
  logic [2:0]   a_w_addr;
  logic [31:0]  a_w_data, a_data;
  logic [0:0]   a_idx;
  logic [31:0]  a_mem [8];
  exp_t         a_q[$];
  int           a_hs_cyc[$];
  int           a_hs_cnt = 0, a_done_cnt = 0, a_wen_cnt = 0, a_done_cyc = 0, a_exp_done = 0;

  fc_layer #(.IN_LEN(4), .OUT_LEN(2), .FRAC(0)) dut_a (
    .clk(clk), .rst(a_rst), .start(a_start), .in_map(a_in),
    .w_en(a_w_en), .w_addr(a_w_addr), .w_data(a_w_data),
    .out_valid(a_valid), .out_ready(a_ready), .out_data(a_data), .out_idx(a_idx),
    .busy(a_busy), .done(a_done)
  );

  always @(posedge clk) a_w_data <= a_w_en ? a_mem[a_w_addr] : $urandom;

  always @(negedge clk) if (!a_rst) begin
    if (a_w_en) a_wen_cnt++;
    if (a_valid) begin
      check("a_wen_while_valid", a_w_en, 0);
      if (a_q.size() == 0) check("a_unexpected_valid", a_valid, 0);
      else begin
        check("a_idx", a_idx, a_q[0].idx);
        check("a_data", a_data, a_q[0].data);
        if (a_ready) begin
          void'(a_q.pop_front());
          a_hs_cnt++;
          a_hs_cyc.push_back(cyc);
        end
      end
    end
    if (a_done) begin
      a_done_cnt++;
      a_done_cyc = cyc;
    end
  end

  function automatic logic [127:0] pack4(input int e0, input int e1, input int e2, input int e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic a_push(input logic [127:0] v);
    logic signed [63:0] acc, e, w;
    for (int o = 0; o < 2; o++) begin
      acc = '0;
      for (int k = 0; k < 4; k++) begin
        e = $signed(v[k*32 +: 32]);
        w = $signed(a_mem[o*4 + k]);
        acc += e * w;
      end
      a_q.push_back('{idx: o, data: reduce(acc, 0)});
    end
  endtask

  task automatic a_start_pulse(input logic [127:0] v, output int t0);
    @(posedge clk); #1;
    a_in = v; a_start = 1'b1; t0 = cyc;
    @(posedge clk); #1;
    a_start = 1'b0;
  endtask

  task automatic a_wait_done(input int budget);
    int n;
    n = 0;
    while (!a_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    check("a_done_timeout", a_done, 1);
  endtask

  // ---------------- instance B: fixed point, FRAC=16 ----------------
  logic        b_start, b_w_en, b_valid, b_busy, b_done;
  logic [31:0] b_in, b_w_data, b_data;
  logic [0:0]  b_w_addr, b_idx;
  logic [31:0] b_mem [2];
  exp_t        b_q[$];
  int          b_done_cnt = 0;

  fc_layer #(.IN_LEN(1), .OUT_LEN(2), .FRAC(16)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .in_map(b_in),
    .w_en(b_w_en), .w_addr(b_w_addr), .w_data(b_w_data),
    .out_valid(b_valid), .out_ready(1'b1), .out_data(b_data), .out_idx(b_idx),
    .busy(b_busy), .done(b_done)
  );

  always @(posedge clk) b_w_data <= b_w_en ? b_mem[b_w_addr] : $urandom;

  always @(negedge clk) if (!rst) begin
    if (b_done) b_done_cnt++;
    if (b_valid) begin
      if (b_q.size() == 0) check("b_unexpected_valid", b_valid, 0);
      else begin
        check("b_idx", b_idx, b_q[0].idx);
        check("b_data", b_data, b_q[0].data);
        void'(b_q.pop_front());
      end
    end
  end

  // ---------------- instance C: saturation / wrap, FRAC=0 ----------------
  logic        c_start, c_w_en, c_valid, c_busy, c_done;
  logic [31:0] c_in, c_w_data, c_data;
  logic [0:0]  c_w_addr, c_idx;
  logic [31:0] c_mem [2];
  exp_t        c_q[$];
  int          c_done_cnt = 0;

  fc_layer #(.IN_LEN(1), .OUT_LEN(2), .FRAC(0)) dut_c (
    .clk(clk), .rst(rst), .start(c_start), .in_map(c_in),
    .w_en(c_w_en), .w_addr(c_w_addr), .w_data(c_w_data),
    .out_valid(c_valid), .out_ready(1'b1), .out_data(c_data), .out_idx(c_idx),
    .busy(c_busy), .done(c_done)
  );

  always @(posedge clk) c_w_data <= c_w_en ? c_mem[c_w_addr] : $urandom;

  always @(negedge clk) if (!rst) begin
    if (c_done) c_done_cnt++;
    if (c_valid) begin
      if (c_q.size() == 0) check("c_unexpected_valid", c_valid, 0);
      else begin
        check("c_idx", c_idx, c_q[0].idx);
        check("c_data", c_data, c_q[0].data);
        void'(c_q.pop_front());
      end
    end
  end

  // ---------------- instance D: default size, random data and backpressure ----------------
  logic          d_start, d_ready, d_w_en, d_valid, d_busy, d_done;
  logic [6271:0] d_in;
  logic [10:0]   d_w_addr;
  logic [31:0]   d_w_data, d_data;
  logic [3:0]    d_idx;
  logic [31:0]   d_mem [1960];
  exp_t          d_q[$];
  int            d_done_cnt = 0;
  logic          d_run = 1'b0;

  fc_layer dut_d (
    .clk(clk), .rst(rst), .start(d_start), .in_map(d_in),
    .w_en(d_w_en), .w_addr(d_w_addr), .w_data(d_w_data),
    .out_valid(d_valid), .out_ready(d_ready), .out_data(d_data), .out_idx(d_idx),
    .busy(d_busy), .done(d_done)
  );

  always @(posedge clk) d_w_data <= d_w_en ? d_mem[d_w_addr] : $urandom;

  always @(negedge clk) if (!rst) begin
    if (d_done) d_done_cnt++;
    if (d_valid && d_ready) begin
      if (d_q.size() == 0) check("d_unexpected_valid", d_valid, 0);
      else begin
        check("d_idx", d_idx, d_q[0].idx);
        check("d_data", d_data, d_q[0].data);
        void'(d_q.pop_front());
      end
    end
  end

  initial begin
    d_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (d_run) d_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic d_push();
    logic signed [63:0] acc, e, w;
    for (int o = 0; o < 10; o++) begin
      acc = '0;
      for (int k = 0; k < 196; k++) begin
        e = $signed(d_in[k*32 +: 32]);
        w = $signed(d_mem[o*196 + k]);
        acc += e * w;
      end
      d_q.push_back('{idx: o, data: reduce(acc, 16)});
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t0, wen0, hs0, done0, n;
    rst = 1'b1; a_rst = 1'b1;
    a_start = 1'b0; a_ready = 1'b1; a_in = '0;
    b_start = 1'b0; b_in = '0; c_start = 1'b0; c_in = '0; d_start = 1'b0; d_in = '0;
    a_mem = '{32'd1, 32'd1, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd2, 32'd1};
    b_mem = '{32'h0002_0000, 32'hFFFF_0000};
    c_mem = '{32'h7FFF_FFFF, 32'h8000_0001};
    for (int j = 0; j < 1960; j++)
      d_mem[j] = ((j / 196) % 2 == 1) ? $urandom : 32'(int'($urandom_range(0, 262143)) - 131072);
    for (int k = 0; k < 196; k++)
      d_in[k*32 +: 32] = 32'(int'($urandom_range(0, 262143)) - 131072);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_w_en", a_w_en, 0);
    check("rst_w_addr", a_w_addr, 0);
    check("rst_out_valid", a_valid, 0);
    check("rst_out_data", a_data, 0);
    check("rst_out_idx", a_idx, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    @(posedge clk); #1;
    rst = 1'b0; a_rst = 1'b0;

    // Launch B, C and D; they run alongside the directed A sequence.
    b_in = 32'h0001_8000;
    b_q.push_back('{idx: 0, data: 32'h0003_0000});
    b_q.push_back('{idx: 1, data: 32'hFFFE_8000});
    c_in = 32'h7FFF_FFFF;
`ifdef FC_SAT_EN
    c_q.push_back('{idx: 0, data: 32'h7FFF_FFFF});
    c_q.push_back('{idx: 1, data: 32'h8000_0000});
`else
    c_q.push_back('{idx: 0, data: 32'h0000_0001});
    c_q.push_back('{idx: 1, data: 32'hFFFF_FFFF});
`endif
    d_push();
    b_start = 1'b1; c_start = 1'b1; d_start = 1'b1; d_run = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0; c_start = 1'b0; d_start = 1'b0;

    // Basic run with exact cycle timing.
    a_hs_cyc.delete();
    wen0 = a_wen_cnt;
    a_push(pack4(1, 2, 3, 4));
    a_start_pulse(pack4(1, 2, 3, 4), t0);
    check("a_busy_rise", a_busy, 1);
    check("a_first_w_en", a_w_en, 1);
    check("a_first_w_addr", a_w_addr, 0);
    a_wait_done(60);
    a_exp_done++;
    check("a_hs_count", a_hs_cyc.size(), 2);
    if (a_hs_cyc.size() == 2) begin
      check("a_hs0_cycle", a_hs_cyc[0], t0 + 6);
      check("a_hs1_cycle", a_hs_cyc[1], t0 + 12);
    end
    check("a_done_cycle", a_done_cyc, t0 + 13);
    check("a_busy_fall", a_busy, 0);
    check("a_w_en_count", a_wen_cnt - wen0, 8);

    // Backpressure on neuron 0.
    wen0 = a_wen_cnt;
    a_ready = 1'b0;
    a_push(pack4(-3, 5, 7, -2));
    a_start_pulse(pack4(-3, 5, 7, -2), t0);
    n = 0;
    while (!a_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("a_bp_valid_seen", a_valid, 1);
    repeat (5) @(negedge clk);
    check("a_bp_still_valid", a_valid, 1);
    @(posedge clk); #1;
    a_ready = 1'b1;
    a_wait_done(60);
    a_exp_done++;
    check("a_bp_w_en_count", a_wen_cnt - wen0, 8);

    // Reset in the middle of MAC, then a clean pass.
    hs0 = a_hs_cnt;
    a_start_pulse(pack4(9, 9, 9, 9), t0);
    @(posedge clk); #1;
    a_rst = 1'b1;
    @(posedge clk); #1;
    check("a_rst_busy", a_busy, 0);
    check("a_rst_w_en", a_w_en, 0);
    a_rst = 1'b0;
    repeat (20) @(negedge clk);
    check("a_rst_no_handshake", a_hs_cnt - hs0, 0);
    check("a_rst_no_done", a_done_cnt, a_exp_done);
    a_push(pack4(1, 2, 3, 4));
    a_start_pulse(pack4(1, 2, 3, 4), t0);
    a_wait_done(60);
    a_exp_done++;

    // Start pulsed with a different vector while busy must be ignored.
    hs0 = a_hs_cnt;
    done0 = a_done_cnt;
    a_push(pack4(2, -1, 4, 6));
    a_start_pulse(pack4(2, -1, 4, 6), t0);
    @(posedge clk); #1;
    a_in = pack4(100, 200, 300, 400); a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    a_wait_done(60);
    a_exp_done++;
    repeat (4) @(negedge clk);
    check("a_busy_start_hs", a_hs_cnt - hs0, 2);
    check("a_busy_start_done", a_done_cnt - done0, 1);

    // Let the full-size instance finish.
    n = 0;
    while (d_done_cnt == 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    #1;
    check("d_done_seen", d_done_cnt, 1);
    repeat (3) @(negedge clk);

    check("a_queue_empty", a_q.size(), 0);
    check("a_done_total", a_done_cnt, a_exp_done);
    check("b_queue_empty", b_q.size(), 0);
    check("b_done_total", b_done_cnt, 1);
    check("c_queue_empty", c_q.size(), 0);
    check("c_done_total", c_done_cnt, 1);
    check("d_queue_empty", d_q.size(), 0);
    check("d_busy_idle", d_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
